// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: NOP encoding, opcode values, word/address
// typedefs, the fetch-mode encoding and the branch-target helper.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam word_t      NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BLEU   = 6'h16;

  // What the IF/ID register does this cycle.
  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_STALL,
    FETCH_SQUASH
  } fetch_mode_e;

  // Branch offsets are signed word counts relative to the instruction after the branch.
  function automatic addr_t branch_target(addr_t base, logic [15:0] offset);
    return base + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: sequential PC+4, or a redirect from
// decode (jump beats taken branch). Redirects count only while IF/ID is valid.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_pc_plus4,
  input  logic        if_valid,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] next_pc,
  output logic        redirect
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    if (if_valid) begin
      if (jump) begin
        next_pc  = {if_pc_plus4[31:28], jump_target, 2'b00};
        redirect = 1'b1;
      end else if (branch_taken) begin
        next_pc  = branch_target(if_pc_plus4, branch_offset);
        redirect = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID register.
// Optional out-of-range fetch detection is enabled by defining FETCH_BOUND_CHECK_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault
);

  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic        out_of_range;
  fetch_mode_e mode;

  assign imem_addr = pc;

  fetch_next_pc u_next_pc (
    .pc            (pc),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // A redirect squashes the wrong-path fetch even when decode is stalled.
  always_comb begin
    mode = FETCH_RUN;
    if (redirect)   mode = FETCH_SQUASH;
    else if (stall) mode = FETCH_STALL;
  end

`ifdef FETCH_BOUND_CHECK_EN
  assign out_of_range = (pc[31:2] >= MEM_WORDS_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              fetch_fault <= 1'b0;
    else if (mode == FETCH_RUN && out_of_range) fetch_fault <= 1'b1;
  end
`else
  assign out_of_range = 1'b0;
  assign fetch_fault  = 1'b0;

  // Bound parameter is only consulted by the optional check.
  logic unused_bound;
  assign unused_bound = (MEM_WORDS_W == '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      pc          <= RESET_PC;
      if_instr    <= NOP_INSTR;
      if_pc_plus4 <= 32'h0;
      if_valid    <= 1'b0;
    end else begin
      case (mode)
        FETCH_SQUASH: begin
          pc       <= next_pc;
          if_instr <= NOP_INSTR;
          if_valid <= 1'b0;
        end
        FETCH_STALL: ;
        FETCH_RUN: begin
          pc          <= next_pc;
          if_pc_plus4 <= next_pc;
          if (out_of_range) begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
          end else begin
            if_instr <= imem_rdata;
            if_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/branch/jump traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [20];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault;

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // 20-word instruction memory; unbacked addresses return the inverted address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a < 32'd80) return mem[a[6:2]];
    return ~a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(bit st, bit br, logic [15:0] off, bit j, logic [25:0] jt);
    stall = st; branch_taken = br; branch_offset = off; jump = j; jump_target = jt;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // One clock of the fetch rules, using the inputs presented before the edge.
  task automatic model_clock();
    int so;
    if (m_valid && (jump || branch_taken)) begin
      if (jump) m_pc = (m_pc4 & 32'hF000_0000) + (32'(jump_target) * 4);
      else begin
        so   = int'($signed(branch_offset));
        m_pc = m_pc4 + 32'(so * 4);
      end
      m_valid = 1'b0;
      m_instr = 32'h0;
    end else if (!stall) begin
      m_pc4 = m_pc + 4;
      if (BOUND && (m_pc / 4) >= 20) begin
        m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        m_instr = mem_word(m_pc); m_valid = 1'b1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_instr", if_instr, m_instr);
    if (m_valid) check("if_pc_plus4", if_pc_plus4, m_pc4);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  // Asynchronous reset assertion between edges, released on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_pc4", if_pc_plus4, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 20; i++) mem[i] = $urandom ^ (32'(i) << 24);

    // Reset, then free-running fetch
    #2;
    do_reset();
    step();
    check("s1_valid_rise", 32'(if_valid), 32'd1);
    check("s1_instr0", if_instr, mem[0]);
    check("s1_pc4", if_pc_plus4, 32'd4);
    step();
    check("s1_instr1", if_instr, mem[1]);
    check("s1_addr8", imem_addr, 32'd8);

    // Stall three cycles at PC=8, then resume
    set_in(1, 0, 16'h0, 0, 26'h0);
    repeat (3) step();
    check("s2_addr_hold", imem_addr, 32'd8);
    check("s2_instr_hold", if_instr, mem[1]);
    set_in(0, 0, 16'h0, 0, 26'h0);
    step();
    check("s2_resume", if_instr, mem[2]);
    step();
    check("s3_pc4_16", if_pc_plus4, 32'd16);

    // Taken branch, offset +2 words from 16
    set_in(0, 1, 16'h0002, 0, 26'h0);
    step();
    check("s3_addr24", imem_addr, 32'd24);
    check("s3_bubble", 32'(if_valid), 32'd0);
    set_in(0, 0, 16'h0, 0, 26'h0);
    step();
    check("s3_instr6", if_instr, mem[6]);
    step();
    check("s4_pc4_32", if_pc_plus4, 32'd32);

    // Jump with stall and branch also asserted: jump wins
    set_in(1, 1, 16'h0010, 1, 26'h5);
    step();
    check("s4_addr20", imem_addr, 32'd20);
    check("s4_bubble", 32'(if_valid), 32'd0);
    set_in(0, 0, 16'h0, 0, 26'h0);
    step();
    check("s4_instr5", if_instr, mem[5]);

    // Jump back to word 2 so if_pc_plus4 becomes 12, then branch -2 words
    set_in(0, 0, 16'h0, 1, 26'h2);
    step();
    set_in(0, 0, 16'h0, 0, 26'h0);
    step();
    check("s5_pc4_12", if_pc_plus4, 32'd12);
    set_in(0, 1, 16'hFFFE, 0, 26'h0);
    step();
    check("s5_addr4", imem_addr, 32'd4);
    set_in(0, 0, 16'h0, 0, 26'h0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("s5_async_pc", imem_addr, 32'd0);
    check("s5_async_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Run past the last backed word (PC=80)
    repeat (21) step();
`ifdef FETCH_BOUND_CHECK_EN
    check("s6_fault", 32'(fetch_fault), 32'd1);
    check("s6_invalid", 32'(if_valid), 32'd0);
`else
    check("s6_nofault", 32'(fetch_fault), 32'd0);
    check("s6_passthru", if_instr, ~32'd80);
`endif
    repeat (3) step();

    // Randomized stall / branch / jump traffic with periodic resets
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int c = 0; c < 50; c++) begin
        logic [15:0] off;
        off = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
        set_in($urandom % 4 == 0, $urandom % 6 == 0, off,
               $urandom % 10 == 0, 26'($urandom_range(0, 19)));
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
